// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding imem requests and
// presents fetched words to decode through a valid/ready output register.
module fetch_unit #(
  parameter int unsigned           ARCH_WIDTH = 32,
  parameter logic [ARCH_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ARCH_WIDTH-1:0] next_pc_i,
  input  logic                  redirect_i,
  output logic [ARCH_WIDTH-1:0] pc_plus4_o,
  output logic                  imem_req_o,
  output logic [ARCH_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [ARCH_WIDTH-1:0] imem_rdata_i,
  output logic                  if_valid_o,
  output logic [ARCH_WIDTH-1:0] if_pc_o,
  output logic [ARCH_WIDTH-1:0] if_instr_o,
  input  logic                  id_ready_i
);

  typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

  state_e                state_q;
  logic [ARCH_WIDTH-1:0] pc_q;
  logic [ARCH_WIDTH-1:0] fetch_addr_q;
  logic                  can_issue;

  assign pc_plus4_o  = pc_q + ARCH_WIDTH'(4);
  assign imem_addr_o = pc_q;
  // Only one request in flight, so the response always lands in an empty register.
  assign can_issue   = !if_valid_o || id_ready_i;

  always_comb begin
    imem_req_o = 1'b0;
    if (!rst && state_q == StReq) begin
      imem_req_o = can_issue && !redirect_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      fetch_addr_q <= '0;
      if_valid_o   <= 1'b0;
      if_pc_o      <= '0;
      if_instr_o   <= '0;
    end else begin
      if (if_valid_o && id_ready_i) begin
        if_valid_o <= 1'b0;
      end
      // Redirect flushes the presented word and retargets the PC in every state.
      if (redirect_i) begin
        pc_q       <= next_pc_i;
        if_valid_o <= 1'b0;
      end
      unique case (state_q)
        StReq: begin
          if (imem_req_o && imem_gnt_i) begin
            pc_q         <= next_pc_i;
            fetch_addr_q <= pc_q;
            state_q      <= StWait;
          end
        end
        StWait: begin
          if (imem_rvalid_i) begin
            if (!redirect_i) begin
              if_valid_o <= 1'b1;
              if_pc_o    <= fetch_addr_q;
              if_instr_o <= imem_rdata_i;
            end
            state_q <= StReq;
          end else if (redirect_i) begin
            state_q <= StDrop;
          end
        end
        StDrop: begin
          if (imem_rvalid_i) begin
            state_q <= StReq;
          end
        end
        default: state_q <= StReq;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table for the corner cases, then random
// traffic checked against a program-flow scoreboard and a simple memory model.
module tb_fetch_unit;

  localparam logic [31:0] RstPc = 32'h0000_0100;
  localparam bit T = 1'b1;
  localparam bit F = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] next_pc_i;
  logic        redirect_i = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] pc_plus4_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        id_ready_i = 1'b0;

  int nvec = 0;
  int nerr = 0;

  // External next-PC mux: sequential unless redirecting.
  assign next_pc_i = redirect_i ? tgt : pc_plus4_o;

  fetch_unit #(.ARCH_WIDTH(32), .RESET_PC(RstPc)) dut (
    .clk          (clk),
    .rst          (rst),
    .next_pc_i    (next_pc_i),
    .redirect_i   (redirect_i),
    .pc_plus4_o   (pc_plus4_o),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .if_valid_o   (if_valid_o),
    .if_pc_o      (if_pc_o),
    .if_instr_o   (if_instr_o),
    .id_ready_i   (id_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, redir;
    logic [31:0] tgt;
    bit          gnt, rv;
    logic [31:0] rdata;
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          vld, chkd;
    logic [31:0] pc, instr;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst redir tgt gnt rv rdata rdy | req addr vld chkd pc instr
    tv.push_back('{T, F, 32'h0, F, F, 32'h0, F, F, 32'h100, F, T, 32'h0, 32'h0});
    tv.push_back('{F, F, 32'h0, T, F, 32'h0, T, T, 32'h100, F, F, 32'h0, 32'h0});
    tv.push_back('{F, F, 32'h0, T, T, 32'h13, T, F, 32'h104, F, F, 32'h0, 32'h0});
    for (int k = 0; k < 5; k++)
      tv.push_back('{F, F, 32'h0, T, F, 32'h0, F, F, 32'h104, T, T, 32'h100, 32'h13});
    tv.push_back('{F, F, 32'h0, T, F, 32'h0, T, T, 32'h104, T, T, 32'h100, 32'h13});
    // redirect in S_WAIT before rvalid, late response dropped
    tv.push_back('{F, T, 32'h200, F, F, 32'h0, T, F, 32'h108, F, F, 32'h0, 32'h0});
    tv.push_back('{F, F, 32'h0, F, F, 32'h0, T, F, 32'h200, F, F, 32'h0, 32'h0});
    tv.push_back('{F, F, 32'h0, F, T, 32'hDEADBEEF, T, F, 32'h200, F, F, 32'h0, 32'h0});
    tv.push_back('{F, F, 32'h0, T, F, 32'h0, T, T, 32'h200, F, F, 32'h0, 32'h0});
    tv.push_back('{F, F, 32'h0, F, T, 32'h11111111, F, F, 32'h204, F, F, 32'h0, 32'h0});
    // redirect while presenting under backpressure
    tv.push_back('{F, T, 32'h300, T, F, 32'h0, F, F, 32'h204, T, T, 32'h200, 32'h11111111});
    tv.push_back('{F, F, 32'h0, T, F, 32'h0, F, T, 32'h300, F, F, 32'h0, 32'h0});
    // redirect coinciding with rvalid
    tv.push_back('{F, T, 32'h200, F, T, 32'hDEADBEEF, F, F, 32'h304, F, F, 32'h0, 32'h0});
    tv.push_back('{F, F, 32'h0, T, F, 32'h0, T, T, 32'h200, F, F, 32'h0, 32'h0});
    // wrap at top of address space
    tv.push_back('{F, T, 32'hFFFFFFFC, F, F, 32'h0, T, F, 32'h204, F, F, 32'h0, 32'h0});
    tv.push_back('{F, F, 32'h0, F, T, 32'h0BADF00D, T, F, 32'hFFFFFFFC, F, F, 32'h0, 32'h0});
    tv.push_back('{F, F, 32'h0, T, F, 32'h0, T, T, 32'hFFFFFFFC, F, F, 32'h0, 32'h0});
    tv.push_back('{F, F, 32'h0, F, T, 32'h22, T, F, 32'h0, F, F, 32'h0, 32'h0});
    tv.push_back('{F, F, 32'h0, T, F, 32'h0, T, T, 32'h0, T, T, 32'hFFFFFFFC, 32'h22});
    // reset in S_WAIT, late rvalid ignored
    tv.push_back('{T, F, 32'h0, F, F, 32'h0, T, F, 32'h4, F, F, 32'h0, 32'h0});
    tv.push_back('{F, F, 32'h0, F, T, 32'hDEADBEEF, T, T, 32'h100, F, F, 32'h0, 32'h0});
    tv.push_back('{F, F, 32'h0, F, F, 32'h0, T, T, 32'h100, F, T, 32'h0, 32'h0});

    repeat (2) @(posedge clk);
    foreach (tv[i]) begin
      @(posedge clk); #1;
      rst           = tv[i].rst;
      redirect_i    = tv[i].redir;
      tgt           = tv[i].tgt;
      imem_gnt_i    = tv[i].gnt;
      imem_rvalid_i = tv[i].rv;
      imem_rdata_i  = tv[i].rdata;
      id_ready_i    = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), 32'(imem_req_o), 32'(tv[i].req));
      chk($sformatf("v%0d_addr", i), imem_addr_o, tv[i].addr);
      chk($sformatf("v%0d_pcp4", i), pc_plus4_o, tv[i].addr + 32'd4);
      chk($sformatf("v%0d_valid", i), 32'(if_valid_o), 32'(tv[i].vld));
      if (tv[i].chkd) begin
        chk($sformatf("v%0d_ifpc", i), if_pc_o, tv[i].pc);
        chk($sformatf("v%0d_instr", i), if_instr_o, tv[i].instr);
      end
    end

    // Random phase from a fresh reset.
    @(posedge clk); #1;
    rst = 1'b1; redirect_i = 1'b0; imem_rvalid_i = 1'b0; imem_gnt_i = 1'b0;
    begin
      logic [31:0] fa_exp, exp_pc, paddr;
      bit          pend, hold_exp, redir_prev;
      int          wcnt, nhs;
      fa_exp = RstPc; exp_pc = RstPc; paddr = '0;
      pend = 0; hold_exp = 0; redir_prev = 0; wcnt = 0; nhs = 0;
      for (int c = 0; c < 3000; c++) begin
        @(posedge clk); #1;
        rst           = 1'b0;
        redirect_i    = ($urandom_range(0, 9) == 0);
        tgt           = $urandom & 32'hFFFF_FFFC;
        id_ready_i    = ($urandom_range(0, 9) < 6);
        imem_gnt_i    = ($urandom_range(0, 9) < 7);
        imem_rvalid_i = pend && (wcnt == 0);
        imem_rdata_i  = imem_rvalid_i ? mem(paddr) : $urandom;
        @(negedge clk);
        chk("r_addr", imem_addr_o, fa_exp);
        chk("r_pcp4", pc_plus4_o, fa_exp + 32'd4);
        if (hold_exp) chk("r_valid_hold", 32'(if_valid_o), 32'd1);
        if (redir_prev) chk("r_flush", 32'(if_valid_o), 32'd0);
        if (if_valid_o) begin
          chk("r_ifpc", if_pc_o, exp_pc);
          chk("r_instr", if_instr_o, mem(exp_pc));
        end
        if (if_valid_o && !id_ready_i) chk("r_req_bp", 32'(imem_req_o), 32'd0);
        if (redirect_i) chk("r_req_redir", 32'(imem_req_o), 32'd0);
        if (imem_req_o && imem_gnt_i) begin
          chk("r_one_outstanding", 32'(pend), 32'd0);
        end
        if (imem_rvalid_i) pend = 0;
        else if (pend) wcnt--;
        if (imem_req_o && imem_gnt_i) begin
          pend   = 1;
          paddr  = imem_addr_o;
          wcnt   = $urandom_range(0, 2);
          fa_exp = fa_exp + 32'd4;
        end
        if (if_valid_o && id_ready_i) begin
          nhs++;
          exp_pc = exp_pc + 32'd4;
        end
        hold_exp   = if_valid_o && !id_ready_i && !redirect_i;
        redir_prev = redirect_i;
        if (redirect_i) begin
          exp_pc = tgt;
          fa_exp = tgt;
        end
      end
      chk("r_progress", 32'(nhs > 100), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
